dose_alarm_sequencer: RTL and testbench
=======================================

# dose_alarm_sequencer

Schedule engine that sits directly downstream of the medicine-reminder ROM and consumes its 4-bit data words. It walks the ROM address by address. Each word is the number of time-base ticks until the next dose. When that count expires the block raises an alarm and holds it until the user acknowledges or a timeout elapses. It counts missed doses and flags completion when the schedule ends.

## Interface
Parameters:
- ADDR_W, 5, ROM address width; the schedule holds at most 2^ADDR_W entries.
- TIMEOUT, 8, number of ticks the alarm stays up without Ack before the dose counts as missed (legal range 1..15).

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- Rst  in  1  asynchronous, active-low reset.
- Tick  in  1  time-base strobe, one Clk cycle wide.
- RomData  in  4  ROM word; valid one cycle after RomAddr changes (synchronous ROM).
- Ack  in  1  user acknowledge, sampled as a level.
- RomAddr  out  ADDR_W  current schedule address.
- Alarm  out  1  dose-due indicator (registered).
- Missed  out  1  one-cycle pulse when a dose times out.
- MissCount  out  4  missed-dose count, saturates at 15.
- Done  out  1  schedule finished; held high.

## Operation
States are FETCH, LOAD, WAIT, ALARM and DONE. Reset forces FETCH.
- FETCH: RomAddr is stable. Always go to LOAD on the next edge.
- LOAD: capture RomData into the 4-bit down-counter.
  - RomData == 0 is the end-of-schedule marker: go to DONE.
  - Otherwise go to WAIT.
- WAIT: decrement the counter on each Tick.
  - A Tick while the counter == 1 goes to ALARM and sets Alarm.
- ALARM: Alarm = 1; the timeout counter increments on each Tick.
  - Ack = 1: clear Alarm and advance.
  - Timeout counter reaches TIMEOUT: pulse Missed, increment MissCount (saturating at 15), clear Alarm, advance.
- Advance:
  - RomAddr == 2^ADDR_W−1: go to DONE. The address does not wrap.
  - Otherwise RomAddr+1, go to FETCH, and clear the timeout counter.
- DONE: Done = 1, Alarm = 0, RomAddr frozen. Only reset leaves this state.
- Ticks in FETCH and LOAD are ignored, so they do not shorten the interval.
- Ack outside ALARM is ignored.
- Ack and the timeout-completing Tick in the same cycle: Ack wins. No Missed pulse, MissCount unchanged.
- Reset mid-operation, at any state: all outputs return to their reset values immediately and asynchronously. The schedule restarts at address 0 after Rst deasserts.

## Timing
- Reset values: RomAddr = 0, Alarm = 0, Missed = 0, MissCount = 0, Done = 0. Internal counters are 0 and the state is FETCH.
- First cycle after Rst deasserts is FETCH with address 0; the next cycle is LOAD.
- Word N with value V: Alarm rises on the edge following the V-th Tick counted in WAIT.
- Ack sampled high in cycle c: Alarm = 0 and RomAddr = N+1 from edge c+1.
- Fetching the next word costs 2 cycles (FETCH, LOAD) before Ticks are counted again.
- Missed is high exactly one cycle, coincident with Alarm falling.
- Done rises on the edge after the LOAD that sees 0, or on the edge after the advance from the last address.

## Structure
- Shared package (reminder_pkg) holds:
  - the state enum {FETCH, LOAD, WAIT, ALARM, DONE};
  - the constant END_MARKER = 4'd0;
  - ROM word width = 4, shared with the ROM top module.
- One natural sub-module, tick_counter: a loadable 4-bit down-counter with a Tick enable and a zero/one flag. The WAIT interval uses it.
- The timeout and miss counters stay inline.

## Test plan
- ROM model [2,1,0], Ack each alarm after 1 cycle:
  - Alarm rises after Tick #2, then after one more Tick;
  - RomAddr steps 0→1→2;
  - Done = 1 after address 2 loads; MissCount = 0.
- ROM [3,0], no Ack, TIMEOUT = 8:
  - Alarm held for 8 Ticks;
  - Missed pulses once, MissCount = 1;
  - then Done = 1.
- Ack asserted on the same cycle as the 8th timeout Tick: Missed stays 0, MissCount = 0, RomAddr advances.
- Twenty consecutive missed doses: MissCount saturates at 15 and never wraps.
- ROM entirely non-zero with ADDR_W = 2 (4 words of 1): after the 4th acknowledged alarm, Done = 1 and RomAddr stays at 3.
- Rst pulsed low while in ALARM at address 1:
  - Alarm and RomAddr go to 0 immediately, without waiting for a Clk edge;
  - after release the first word is re-fetched.

Source files
------------

// File: rtl/reminder_pkg.sv
// rtl/reminder_pkg.sv - shared state encoding and ROM word constants for the reminder schedule
package reminder_pkg;

  localparam int WORD_W = 4;
  localparam logic [WORD_W-1:0] END_MARKER = 4'd0;

  typedef enum logic [2:0] {
    FETCH,
    LOAD,
    WAIT,
    ALARM,
    DONE
  } state_t;

  function automatic logic [3:0] sat_inc4(input logic [3:0] value);
    return (value == 4'hF) ? value : value + 4'd1;
  endfunction

endpackage

// File: rtl/tick_counter.sv
// rtl/tick_counter.sv - loadable down-counter stepped by the time-base tick
module tick_counter
  import reminder_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic              tick,
  output logic              zero,
  output logic              one
);

  logic [WORD_W-1:0] count;

  // Holds at zero rather than wrapping so a stray tick cannot restart the interval
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_data;
    end else if (tick && (count != '0)) begin
      count <= count - WORD_W'(1);
    end
  end

  assign zero = (count == '0);
  assign one  = (count == WORD_W'(1));

endmodule

// File: rtl/dose_alarm_sequencer.sv
// rtl/dose_alarm_sequencer.sv - walks the reminder ROM, raises dose alarms, counts missed doses
module dose_alarm_sequencer
  import reminder_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 8
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Tick,
  input  logic [WORD_W-1:0] RomData,
  input  logic              Ack,
  output logic [ADDR_W-1:0] RomAddr,
  output logic              Alarm,
  output logic              Missed,
  output logic [3:0]        MissCount,
  output logic              Done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [3:0]        TMO_LAST  = 4'(TIMEOUT - 1);

  state_t     state;
  logic [3:0] tmo_cnt;
  logic       cnt_load;
  logic       cnt_tick;
  logic       cnt_zero;
  logic       cnt_one;
  logic       ack_hit;
  logic       tmo_hit;
  logic       advance;

  assign cnt_load = (state == LOAD);
  assign cnt_tick = (state == WAIT) && Tick;

  tick_counter u_interval (
    .clk       (Clk),
    .rst_n     (Rst),
    .load      (cnt_load),
    .load_data (RomData),
    .tick      (cnt_tick),
    .zero      (cnt_zero),
    .one       (cnt_one)
  );

  // Ack takes priority over a timeout landing in the same cycle
  always_comb begin
    ack_hit = (state == ALARM) && Ack;
    tmo_hit = (state == ALARM) && Tick && (tmo_cnt == TMO_LAST) && !Ack;
    advance = ack_hit || tmo_hit;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state     <= FETCH;
      tmo_cnt   <= 4'd0;
      RomAddr   <= '0;
      Alarm     <= 1'b0;
      Missed    <= 1'b0;
      MissCount <= 4'd0;
      Done      <= 1'b0;
    end else begin
      Missed <= 1'b0;
      case (state)
        FETCH: begin
          state <= LOAD;
        end
        LOAD: begin
          if (RomData == END_MARKER) begin
            state <= DONE;
            Done  <= 1'b1;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (Tick && (cnt_one || cnt_zero)) begin
            state <= ALARM;
            Alarm <= 1'b1;
          end
        end
        ALARM: begin
          if (Tick && !advance) begin
            tmo_cnt <= tmo_cnt + 4'd1;
          end
          if (tmo_hit) begin
            Missed    <= 1'b1;
            MissCount <= sat_inc4(MissCount);
          end
          // The last address finishes the schedule instead of wrapping to 0
          if (advance) begin
            Alarm   <= 1'b0;
            tmo_cnt <= 4'd0;
            if (RomAddr == LAST_ADDR) begin
              state <= DONE;
              Done  <= 1'b1;
            end else begin
              RomAddr <= RomAddr + ADDR_W'(1);
              state   <= FETCH;
            end
          end
        end
        DONE: begin
          Done  <= 1'b1;
          Alarm <= 1'b0;
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dose_alarm_sequencer.sv
// tb/tb_dose_alarm_sequencer.sv - scoreboard bench for the dose alarm sequencer
module tb_dose_alarm_sequencer;

  localparam int EV_RISE = 0;
  localparam int EV_FALL = 1;
  localparam int EV_DONE = 2;

  typedef struct {
    int kind;
    int addr;
    int delta;
    bit missed;
    int mcount;
  } ev_t;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       Tick = 1'b0;
  logic       Ack = 1'b0;
  logic [3:0] rom_data1;
  logic [3:0] rom_data2;
  logic [4:0] addr1;
  logic [1:0] addr2;
  logic       alarm1, alarm2, missed1, missed2, done1, done2;
  logic [3:0] mc1, mc2;

  logic [3:0] rom1 [0:31];
  logic [3:0] rom2 [0:3];

  bit         sel = 1'b0;
  logic [4:0] m_addr;
  logic       m_alarm, m_missed, m_done;
  logic [3:0] m_mc;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  tick_total = 0;
  int  last_mark = 0;
  bit  prev_alarm = 0;
  bit  prev_done = 0;
  bit  prev_missed = 0;

  dose_alarm_sequencer #(.ADDR_W(5), .TIMEOUT(8)) dut1 (
    .Clk(Clk), .Rst(Rst), .Tick(Tick), .RomData(rom_data1), .Ack(Ack),
    .RomAddr(addr1), .Alarm(alarm1), .Missed(missed1), .MissCount(mc1), .Done(done1)
  );

  dose_alarm_sequencer #(.ADDR_W(2), .TIMEOUT(8)) dut2 (
    .Clk(Clk), .Rst(Rst), .Tick(Tick), .RomData(rom_data2), .Ack(Ack),
    .RomAddr(addr2), .Alarm(alarm2), .Missed(missed2), .MissCount(mc2), .Done(done2)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    rom_data1 <= rom1[addr1];
    rom_data2 <= rom2[addr2];
  end

  assign m_addr   = sel ? {3'b000, addr2} : addr1;
  assign m_alarm  = sel ? alarm2 : alarm1;
  assign m_missed = sel ? missed2 : missed1;
  assign m_done   = sel ? done2 : done1;
  assign m_mc     = sel ? mc2 : mc1;

  task automatic push(input int kind, input int addr, input int delta, input bit missed, input int mcount);
    ev_t e;
    e.kind = kind; e.addr = addr; e.delta = delta; e.missed = missed; e.mcount = mcount;
    exp_q.push_back(e);
  endtask

  task automatic check_val(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, act, req);
    end
  endtask

  task automatic check_event(input int kind);
    ev_t e;
    int  delta;
    bit  bad;
    delta = tick_total - last_mark;
    last_mark = tick_total;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event kind=%0d addr=%0d required none", kind, m_addr);
      return;
    end
    e = exp_q.pop_front();
    bad = (e.kind != kind) || (e.addr != int'(m_addr));
    if (kind != EV_DONE && e.delta != delta) bad = 1;
    if (kind == EV_FALL && (e.missed != m_missed || e.mcount != int'(m_mc))) bad = 1;
    if (kind == EV_DONE && (e.mcount != int'(m_mc) || m_alarm)) bad = 1;
    if (bad) begin
      errors++;
      $display("FAIL event got kind=%0d addr=%0d ticks=%0d missed=%0d mcount=%0d alarm=%0d required kind=%0d addr=%0d ticks=%0d missed=%0d mcount=%0d",
               kind, m_addr, delta, m_missed, m_mc, m_alarm, e.kind, e.addr, e.delta, e.missed, e.mcount);
    end
  endtask

  always @(negedge Clk) begin
    if (!Rst) begin
      prev_alarm  = 0;
      prev_done   = 0;
      prev_missed = 0;
      last_mark   = tick_total;
    end else begin
      if (m_alarm && !prev_alarm) check_event(EV_RISE);
      if (!m_alarm && prev_alarm) check_event(EV_FALL);
      if (m_done && !prev_done)   check_event(EV_DONE);
      if (prev_missed) check_val("missed_width", int'(m_missed), 0);
      prev_alarm  = m_alarm;
      prev_done   = m_done;
      prev_missed = m_missed;
    end
  end

  task automatic clear_roms();
    for (int i = 0; i < 32; i++) rom1[i] = 4'd0;
    for (int i = 0; i < 4; i++)  rom2[i] = 4'd0;
  endtask

  task automatic do_reset();
    @(posedge Clk); #1;
    Rst = 1'b0; Tick = 1'b0; Ack = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check_val("rst_addr", int'(m_addr), 0);
    check_val("rst_alarm", int'(m_alarm), 0);
    check_val("rst_missed", int'(m_missed), 0);
    check_val("rst_mcount", int'(m_mc), 0);
    check_val("rst_done", int'(m_done), 0);
    Rst = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
  endtask

  task automatic tick();
    @(posedge Clk); #1;
    Tick = 1'b1;
    tick_total++;
    @(posedge Clk); #1;
    Tick = 1'b0;
  endtask

  task automatic send_ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic tick_with_ack();
    @(posedge Clk); #1;
    Tick = 1'b1; Ack = 1'b1;
    tick_total++;
    @(posedge Clk); #1;
    Tick = 1'b0; Ack = 1'b0;
    repeat (3) @(posedge Clk);
  endtask

  task automatic do_ack();
    @(posedge Clk); #1;
    Ack = 1'b1;
    @(posedge Clk); #1;
    Ack = 1'b0;
    repeat (3) @(posedge Clk);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge Clk);
      n++;
    end
    repeat (2) @(posedge Clk);
    check_val(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired before the summary");
    $fatal(1);
  end

  initial begin
    clear_roms();

    // [2,1,0] acknowledged one cycle after each alarm
    rom1[0] = 4'd2; rom1[1] = 4'd1;
    do_reset();
    push(EV_RISE, 0, 2, 0, 0); send_ticks(2);
    push(EV_FALL, 1, 0, 0, 0); do_ack();
    push(EV_RISE, 1, 1, 0, 0); send_ticks(1);
    push(EV_FALL, 2, 0, 0, 0); push(EV_DONE, 2, 0, 0, 0); do_ack();
    drain("drain_ack_schedule");

    // [3,0] with no acknowledge: one miss after 8 ticks
    clear_roms(); rom1[0] = 4'd3;
    do_reset();
    push(EV_RISE, 0, 3, 0, 0); send_ticks(3);
    push(EV_FALL, 1, 8, 1, 1); push(EV_DONE, 1, 0, 0, 1); send_ticks(8);
    drain("drain_single_miss");

    // Ack together with the timeout-completing tick
    clear_roms(); rom1[0] = 4'd1;
    do_reset();
    push(EV_RISE, 0, 1, 0, 0); send_ticks(1);
    send_ticks(7);
    push(EV_FALL, 1, 8, 0, 0); push(EV_DONE, 1, 0, 0, 0); tick_with_ack();
    drain("drain_ack_vs_timeout");

    // Twenty misses in a row: count saturates at 15
    clear_roms();
    for (int k = 0; k < 20; k++) rom1[k] = 4'd1;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      push(EV_RISE, k, 1, 0, (k < 15) ? k : 15); send_ticks(1);
      push(EV_FALL, k + 1, 8, 1, (k + 1 < 15) ? k + 1 : 15);
      if (k == 19) push(EV_DONE, 20, 0, 0, 15);
      send_ticks(8);
      repeat (3) @(posedge Clk);
    end
    drain("drain_saturation");
    check_val("sat_mcount", int'(mc1), 15);

    // Four-word ROM with no end marker: stops at the last address
    clear_roms();
    for (int k = 0; k < 4; k++) rom2[k] = 4'd1;
    sel = 1'b1;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      push(EV_RISE, k, 1, 0, 0); send_ticks(1);
      push(EV_FALL, (k < 3) ? k + 1 : 3, 0, 0, 0);
      if (k == 3) push(EV_DONE, 3, 0, 0, 0);
      do_ack();
    end
    drain("drain_no_wrap");
    repeat (10) @(posedge Clk);
    #1;
    check_val("no_wrap_addr", int'(addr2), 3);
    check_val("no_wrap_done", int'(done2), 1);
    sel = 1'b0;

    // Asynchronous reset while alarming at address 1
    clear_roms(); rom1[0] = 4'd1; rom1[1] = 4'd1;
    do_reset();
    push(EV_RISE, 0, 1, 0, 0); send_ticks(1);
    push(EV_FALL, 1, 0, 0, 0); do_ack();
    push(EV_RISE, 1, 1, 0, 0); send_ticks(1);
    @(negedge Clk); #2;
    check_val("pre_rst_alarm", int'(alarm1), 1);
    check_val("pre_rst_addr", int'(addr1), 1);
    Rst = 1'b0;
    #1;
    check_val("async_rst_alarm", int'(alarm1), 0);
    check_val("async_rst_addr", int'(addr1), 0);
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    check_val("refetch_queue", exp_q.size(), 0);
    push(EV_RISE, 0, 1, 0, 0); send_ticks(1);
    push(EV_FALL, 1, 0, 0, 0); do_ack();
    push(EV_RISE, 1, 1, 0, 0); send_ticks(1);
    push(EV_FALL, 2, 0, 0, 0); push(EV_DONE, 2, 0, 0, 0); do_ack();
    drain("drain_async_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
